// File: rtl/run_detect_ctrl_if.sv
// rtl/run_detect_ctrl_if.sv - word-in / count-out handshake bundle for run_detect_ctrl
interface run_detect_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, match_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, match_count
  );
endinterface

// File: rtl/run_detect_ctrl.sv
// rtl/run_detect_ctrl.sv - serialises words MSB-first into a run detector and reports z-high counts
// Optional RUN_DETECT_CARRY_RUN_EN: the run survives word boundaries instead of being cleared on accept.
module run_detect_ctrl #(
  parameter int WIDTH   = 16,
  parameter int RUN_LEN = 4,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  run_detect_ctrl_if.slave    bus,
  output logic                busy,
  output logic                cur_bit,
  output logic                z
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RL_W  = $clog2(RUN_LEN + 1);
  localparam logic [RL_W-1:0]  RUN_MAX = RL_W'(RUN_LEN);
  localparam logic [RL_W-1:0]  RUN_ONE = RL_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [RL_W-1:0]  run_len;
  logic [RL_W-1:0]  run_next;
  logic             last_bit;
  logic [CNT_W-1:0] count;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    busy         = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (idx == '0) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // z reflects the run including the bit on w this cycle, so it is taken from run_next.
  always_comb begin
    cur_bit = (state == SHIFT) ? word[idx] : 1'b0;
    if (run_len == '0 || cur_bit != last_bit) begin
      run_next = RUN_ONE;
    end else if (run_len == RUN_MAX) begin
      run_next = RUN_MAX;
    end else begin
      run_next = run_len + 1'b1;
    end
    z = (state == SHIFT) && (run_next == RUN_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      idx      <= '0;
      run_len  <= '0;
      last_bit <= 1'b0;
      count    <= '0;
    end else if (accept) begin
      word  <= bus.in_data;
      idx   <= IDX_W'(WIDTH - 1);
      count <= '0;
`ifndef RUN_DETECT_CARRY_RUN_EN
      run_len  <= '0;
      last_bit <= 1'b0;
`endif
    end else if (state == SHIFT) begin
      run_len  <= run_next;
      last_bit <= cur_bit;
      idx      <= idx - 1'b1;
      if (z && count != CNT_MAX) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.match_count = count;

endmodule

// File: tb/tb_run_detect_ctrl.sv
// tb/tb_run_detect_ctrl.sv - randomized self-checking bench for run_detect_ctrl against a run-count model
module tb_run_detect_ctrl;

  localparam int WIDTH   = 16;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 5;

  logic clk;
  logic reset;
  logic busy;
  logic cur_bit;
  logic z;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: length of the current run of equal bits (unbounded) and its bit value.
  int   m_run  = 0;
  logic m_last = 1'b0;

  run_detect_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  run_detect_ctrl #(.WIDTH(WIDTH), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .busy    (busy),
    .cur_bit (cur_bit),
    .z       (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_match_count"}, bus.match_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cur_bit"}, cur_bit, 0);
    check({tag, "_z"}, z, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_run  = 0;
    m_last = 1'b0;
  endtask

  task automatic accept_word(input logic [WIDTH-1:0] d);
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data  = WIDTH'($urandom);
`ifndef RUN_DETECT_CARRY_RUN_EN
    m_run  = 0;
    m_last = 1'b0;
`endif
  endtask

  task automatic run_word(input logic [WIDTH-1:0] d, input int hold, input int fixed);
    int   cnt;
    logic b;
    logic exp_z;
    cnt = 0;
    accept_word(d);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      b = d[i];
      if (m_run == 0 || b != m_last) m_run = 1;
      else m_run = m_run + 1;
      m_last = b;
      exp_z = (m_run >= RUN_LEN);
      if (exp_z && cnt < (1 << CNT_W) - 1) cnt++;
      @(negedge clk);
      check("shift_cur_bit", cur_bit, b);
      check("shift_z", z, exp_z);
      check("shift_busy", busy, 1);
      check("shift_out_valid", bus.out_valid, 0);
      check("shift_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    check("report_out_valid", bus.out_valid, 1);
    check("report_count", bus.match_count, cnt);
    if (fixed >= 0) check("report_count_fixed", bus.match_count, fixed);
    check("report_z", z, 0);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'($urandom);
      @(negedge clk);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_count", bus.match_count, cnt);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("done_out_valid", bus.out_valid, 0);
    check("done_in_ready", bus.in_ready, 1);
    check("done_busy", busy, 0);
    check("done_count_held", bus.match_count, cnt);
  endtask

  task automatic abort_word();
    int seen;
    seen = 0;
    accept_word(16'h0000);
    repeat (6) @(negedge clk);
    check("abort_busy_before", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    m_run  = 0;
    m_last = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen++;
    end
    check("abort_no_result", seen, 0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_word(16'h0000, 0, 13);
    run_word(16'hAAAA, 0, 0);
    run_word(16'hF0F0, 5, 4);
    abort_word();
    run_word(16'h0000, 0, 13);

    do_reset();
    run_word(16'h000F, 1, 10);
`ifdef RUN_DETECT_CARRY_RUN_EN
    run_word(16'hF000, 0, 13);
`else
    run_word(16'hF000, 0, 10);
`endif

    for (int k = 0; k < 30; k++) begin
      logic [WIDTH-1:0] d;
      case ($urandom_range(0, 3))
        0: d = WIDTH'($urandom);
        1: d = '0;
        2: d = WIDTH'($urandom) | WIDTH'($urandom);
        default: d = WIDTH'($urandom) & WIDTH'($urandom);
      endcase
      run_word(d, int'($urandom_range(0, 3)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
